// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// In auto-reload mode it emits one tc strobe every N enabled cycles.
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic [WIDTH-1:0] reload, reload_next;
  logic             tc_reg, tc_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc_reg <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      reload <= reload_next;
      tc_reg <= tc_next;
    end
  end

  // Priority after clear: load, then enabled count, then hold.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload;
    tc_next     = 1'b0;

    if (load) begin
      count_next  = load_val;
      reload_next = load_val;
      state_next  = (load_val != '0) ? RUN : IDLE;
    end else if (state == RUN && enable) begin
      if (count > WIDTH'(1)) begin
        count_next = count - WIDTH'(1);
      end else begin
        // Terminal cycle: auto_reload is only looked at here.
        tc_next = 1'b1;
        if (auto_reload) begin
          count_next = reload;
        end else begin
          count_next = '0;
          state_next = IDLE;
        end
      end
    end
  end

  assign Q    = count;
  assign tc   = tc_reg;
  assign busy = (state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: each step queues its expected outputs,
// which are popped and compared one edge later.
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       enable = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] Q;
  logic       tc;
  logic       busy;

  countdown_timer #(.WIDTH(4)) dut (
    .clock       (clock),
    .clear       (clear),
    .load        (load),
    .load_val    (load_val),
    .enable      (enable),
    .auto_reload (auto_reload),
    .Q           (Q),
    .tc          (tc),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock step: drive inputs, queue the expectation, compare after the edge.
  task automatic cyc(input logic clr, input logic ld, input logic [3:0] lv,
                     input logic en, input logic ar,
                     input logic [3:0] eq, input logic etc, input logic eb,
                     input string tag);
    exp_t e;
    @(negedge clock);
    clear       = clr;
    load        = ld;
    load_val    = lv;
    enable      = en;
    auto_reload = ar;
    sb.push_back('{q: eq, tc: etc, busy: eb, tag: tag});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.tag, ".q"},    32'(Q),    32'(e.q));
    check({e.tag, ".tc"},   32'(tc),   32'(e.tc));
    check({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
  endtask

  initial begin
    // Reset with a concurrent load: clear must win on both edges.
    cyc(1, 1, 4'd7, 1, 1, 4'd0, 0, 0, "reset0");
    cyc(1, 1, 4'd7, 1, 1, 4'd0, 0, 0, "reset1");
    cyc(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "idle_enable");

    // One-shot from 5.
    cyc(0, 1, 4'd5, 0, 0, 4'd5, 0, 1, "os_load");
    for (int i = 1; i <= 4; i++)
      cyc(0, 0, 4'd0, 1, 0, 4'(5 - i), 0, 1, $sformatf("os_dec%0d", i));
    cyc(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, "os_term");
    cyc(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "os_after0");
    cyc(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "os_after1");

    // Auto-reload from 3: 3,2,1,3,2,1,3 with tc on each return to 3.
    cyc(0, 1, 4'd3, 0, 1, 4'd3, 0, 1, "ar_load");
    for (int p = 0; p < 2; p++) begin
      cyc(0, 0, 4'd0, 1, 1, 4'd2, 0, 1, $sformatf("ar_p%0d_2", p));
      cyc(0, 0, 4'd0, 1, 1, 4'd1, 0, 1, $sformatf("ar_p%0d_1", p));
      cyc(0, 0, 4'd0, 1, 1, 4'd3, 1, 1, $sformatf("ar_p%0d_3", p));
    end

    // Enable gap: 4,3,2,2,2,1,0 with tc two cycles late.
    cyc(0, 1, 4'd4, 0, 0, 4'd4, 0, 1, "gap_load");
    cyc(0, 0, 4'd0, 1, 0, 4'd3, 0, 1, "gap_e1");
    cyc(0, 0, 4'd0, 1, 0, 4'd2, 0, 1, "gap_e2");
    cyc(0, 0, 4'd0, 0, 0, 4'd2, 0, 1, "gap_h1");
    cyc(0, 0, 4'd0, 0, 0, 4'd2, 0, 1, "gap_h2");
    cyc(0, 0, 4'd0, 1, 0, 4'd1, 0, 1, "gap_e3");
    cyc(0, 0, 4'd0, 1, 0, 4'd0, 1, 0, "gap_term");

    // Load colliding with the terminal cycle, then a load of zero.
    cyc(0, 1, 4'd2, 0, 0, 4'd2, 0, 1, "col_load2");
    cyc(0, 0, 4'd0, 1, 0, 4'd1, 0, 1, "col_dec");
    cyc(0, 1, 4'd9, 1, 0, 4'd9, 0, 1, "col_load9");
    cyc(0, 1, 4'd0, 1, 0, 4'd0, 0, 0, "col_load0");
    cyc(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "col_idle");

    // Reload value 1 with auto-reload: tc every enabled cycle.
    cyc(0, 1, 4'd1, 0, 1, 4'd1, 0, 1, "r1_load");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 4'd0, 1, 1, 4'd1, 1, 1, $sformatf("r1_tc%0d", i));
    cyc(0, 0, 4'd0, 0, 1, 4'd1, 0, 1, "r1_hold");

    // auto_reload only matters on the terminal cycle.
    cyc(0, 1, 4'd3, 0, 1, 4'd3, 0, 1, "mid_load");
    cyc(0, 0, 4'd0, 1, 1, 4'd2, 0, 1, "mid_2");
    cyc(0, 0, 4'd0, 1, 0, 4'd1, 0, 1, "mid_1");
    cyc(0, 0, 4'd0, 1, 1, 4'd3, 1, 1, "mid_reload");

    // Full-range load: tc after exactly 15 enabled edges.
    cyc(0, 1, 4'd15, 0, 0, 4'd15, 0, 1, "max_load");
    for (int i = 1; i <= 15; i++)
      cyc(0, 0, 4'd0, 1, 0, 4'(15 - i), (i == 15), (i != 15), $sformatf("max_e%0d", i));

    // Rerun and clear (with load) at Q=2.
    cyc(0, 1, 4'd15, 0, 0, 4'd15, 0, 1, "clr_load");
    for (int i = 1; i <= 13; i++)
      cyc(0, 0, 4'd0, 1, 0, 4'(15 - i), 0, 1, $sformatf("clr_e%0d", i));
    cyc(1, 1, 4'd5, 1, 0, 4'd0, 0, 0, "clr_hit");
    cyc(0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "clr_after0");
    cyc(0, 0, 4'd0, 1, 1, 4'd0, 0, 0, "clr_after1");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
